// File: rtl/clk_div_mgr.sv
// Multi-channel programmable clock-enable divider with align/lock sequencing.
// Optional phase stepping is built only when CLK_DIV_MGR_PHASE_STEP_EN is defined.
module clk_div_mgr #(
  parameter int                        NUM_CH      = 3,
  parameter int                        DIV_W       = 8,
  parameter logic [NUM_CH*DIV_W-1:0]   DIV_INIT    = {8'd32, 8'd16, 8'd16},
  parameter int                        LOCK_CYCLES = 16
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_err,
  input  logic              ps_pulse,
  input  logic [2:0]        ps_sel,
  output logic [NUM_CH-1:0] clkout,
  output logic [NUM_CH-1:0] clken,
  output logic              lock
);

  localparam int LC_W = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {ALIGN, WAIT_LOCK, LOCKED} state_t;

  state_t            state;
  logic [LC_W-1:0]   lock_cnt;
  logic [DIV_W-1:0]  cnt [NUM_CH];
  logic [DIV_W-1:0]  div [NUM_CH];
  logic [NUM_CH-1:0] hold;
  logic              cfg_acc;
  logic              cfg_good;
  logic              cfg_take;

  always_comb begin
    cfg_acc  = cfg_valid && cfg_ready;
    cfg_good = (cfg_div >= DIV_W'(2)) && (int'(cfg_ch) < NUM_CH);
    cfg_take = cfg_acc && cfg_good;
  end

`ifdef CLK_DIV_MGR_PHASE_STEP_EN
  // A phase step freezes one counter for a single cycle; reconfiguration wins.
  always_comb begin
    hold = '0;
    if (state == LOCKED && ps_pulse && !cfg_take) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (int'(ps_sel) == i) hold[i] = 1'b1;
      end
    end
  end
`else
  logic unused_ps;
  assign unused_ps = ps_pulse ^ (^ps_sel);
  assign hold      = '0;
`endif

  always_ff @(posedge clkin) begin
    if (reset) begin
      state     <= ALIGN;
      lock      <= 1'b0;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
      lock_cnt  <= '0;
      clkout    <= '0;
      clken     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
        div[i] <= DIV_INIT[i*DIV_W +: DIV_W];
      end
    end else begin
      cfg_err <= cfg_acc && !cfg_good;

      // Counter stage feeds the registered clock/enable stage one cycle later
      for (int i = 0; i < NUM_CH; i++) begin
        if (state == ALIGN) begin
          cnt[i]    <= '0;
          clkout[i] <= 1'b0;
          clken[i]  <= 1'b0;
        end else begin
          clkout[i] <= cnt[i] < (div[i] >> 1);
          clken[i]  <= cnt[i] == '0;
          if (!hold[i]) begin
            cnt[i] <= (cnt[i] >= div[i] - DIV_W'(1)) ? '0 : cnt[i] + DIV_W'(1);
          end
        end
        if (cfg_take && int'(cfg_ch) == i) div[i] <= cfg_div;
      end

      if (cfg_take) begin
        state     <= ALIGN;
        lock      <= 1'b0;
        cfg_ready <= 1'b0;
      end else begin
        case (state)
          ALIGN: begin
            state     <= WAIT_LOCK;
            lock_cnt  <= '0;
            lock      <= 1'b0;
            cfg_ready <= 1'b1;
          end
          WAIT_LOCK: begin
            lock_cnt <= lock_cnt + LC_W'(1);
            if (lock_cnt == LC_W'(LOCK_CYCLES - 1)) begin
              state <= LOCKED;
              lock  <= 1'b1;
            end
          end
          LOCKED: begin
            lock <= 1'b1;
          end
          default: begin
            state     <= ALIGN;
            lock      <= 1'b0;
            cfg_ready <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_div_mgr.sv
// Bench for clk_div_mgr: vector table, hand sequences and random traffic
// checked against a time-arithmetic reference model.
module tb_clk_div_mgr;

  localparam int NCH  = 3;
  localparam int LOCK = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [2:0] cfg_ch = '0;
  logic [7:0] cfg_div = '0;
  logic       cfg_err;
  logic       ps_pulse = 1'b0;
  logic [2:0] ps_sel = '0;
  logic [2:0] clkout;
  logic [2:0] clken;
  logic       lock;

  clk_div_mgr dut (
    .clkin(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_err(cfg_err),
    .ps_pulse(ps_pulse), .ps_sel(ps_sel), .clkout(clkout), .clken(clken), .lock(lock)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: outputs follow from the edge index of the last align,
  // the per-channel slip count and the current ratios.
  int   t = 0;
  int   a = 0;
  bit   model_on = 0;
  int   div_m [NCH];
  int   slip  [NCH];
  logic [2:0] exp_clkout, exp_clken;
  logic       exp_lock, exp_ready, exp_err;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, expv, t);
    end
  endtask

  task automatic model_edge(input logic r, input logic cv, input logic [2:0] cc,
                            input logic [7:0] cd, input logic pp, input logic [2:0] ps);
    bit rdy, good, take;
    int ph;
    if (r) begin
      exp_clkout = '0; exp_clken = '0;
      exp_lock = 0; exp_ready = 0; exp_err = 0;
      a = t + 1;
      div_m[0] = 16; div_m[1] = 16; div_m[2] = 32;
      for (int i = 0; i < NCH; i++) slip[i] = 0;
      model_on = 1;
    end else begin
      rdy  = (t > a);
      good = (int'(cd) >= 2) && (int'(cc) < NCH);
      take = cv && rdy && good;
      exp_err = cv && rdy && !good;
      for (int i = 0; i < NCH; i++) begin
        if (t == a) begin
          exp_clkout[i] = 1'b0;
          exp_clken[i]  = 1'b0;
        end else begin
          ph = (t - 1 - a - slip[i]) % div_m[i];
          exp_clken[i]  = (ph == 0);
          exp_clkout[i] = (ph < div_m[i] / 2);
        end
      end
      exp_lock  = !take && (t >= a + LOCK);
      exp_ready = !take && (t >= a);
`ifdef CLK_DIV_MGR_PHASE_STEP_EN
      if (!take && pp && int'(ps) < NCH && t > a + LOCK) slip[ps]++;
`endif
      if (take) begin
        div_m[cc] = int'(cd);
        a = t + 1;
        for (int i = 0; i < NCH; i++) slip[i] = 0;
      end
    end
    t++;
  endtask

  task automatic step(input logic r, input logic cv, input logic [2:0] cc,
                      input logic [7:0] cd, input logic pp, input logic [2:0] ps);
    reset = r; cfg_valid = cv; cfg_ch = cc; cfg_div = cd; ps_pulse = pp; ps_sel = ps;
    @(posedge clk);
    model_edge(r, cv, cc, cd, pp, ps);
    #1;
    if (model_on) begin
      check("clkout", 32'(clkout), 32'(exp_clkout));
      check("clken", 32'(clken), 32'(exp_clken));
      check("lock", 32'(lock), 32'(exp_lock));
      check("cfg_ready", 32'(cfg_ready), 32'(exp_ready));
      check("cfg_err", 32'(cfg_err), 32'(exp_err));
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0);
  endtask

  task automatic measure(input int ch, output int hi, output int per);
    logic prev;
    int   n;
    hi = 0; per = 0; n = 0;
    do begin
      prev = clkout[ch];
      idle();
      n++;
    end while (!(prev == 1'b0 && clkout[ch] == 1'b1) && n < 300);
    do begin
      if (clkout[ch]) hi++;
      prev = clkout[ch];
      idle();
      per++;
    end while (!(prev == 1'b0 && clkout[ch] == 1'b1) && per < 300);
  endtask

  typedef struct {
    int         idle;
    logic       rst, cv;
    logic [2:0] cc;
    logic [7:0] cd;
    logic       pp;
    logic [2:0] ps;
    logic       e_lock, e_ready, e_err;
    string      name;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  initial begin
    int hi, per, n, lag, exp_lag;
    logic prev0;
    bit found;
    logic r, cv, pp;
    logic [2:0] cc, ps;
    logic [7:0] cd;

    vecs[0]  = '{0,  1'b1, 1'b0, 3'd0, 8'd0,  1'b0, 3'd0, 1'b0, 1'b0, 1'b0, "reset_a"};
    vecs[1]  = '{0,  1'b1, 1'b0, 3'd0, 8'd0,  1'b0, 3'd0, 1'b0, 1'b0, 1'b0, "reset_b"};
    vecs[2]  = '{0,  1'b0, 1'b0, 3'd0, 8'd0,  1'b0, 3'd0, 1'b0, 1'b1, 1'b0, "align"};
    vecs[3]  = '{14, 1'b0, 1'b0, 3'd0, 8'd0,  1'b0, 3'd0, 1'b0, 1'b1, 1'b0, "lock_edge16"};
    vecs[4]  = '{0,  1'b0, 1'b0, 3'd0, 8'd0,  1'b0, 3'd0, 1'b1, 1'b1, 1'b0, "lock_edge17"};
    vecs[5]  = '{3,  1'b0, 1'b1, 3'd1, 8'd1,  1'b0, 3'd0, 1'b1, 1'b1, 1'b1, "bad_div"};
    vecs[6]  = '{0,  1'b0, 1'b1, 3'd5, 8'd10, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, "bad_ch"};
    vecs[7]  = '{0,  1'b0, 1'b0, 3'd0, 8'd0,  1'b0, 3'd0, 1'b1, 1'b1, 1'b0, "err_clear"};
    vecs[8]  = '{0,  1'b0, 1'b1, 3'd1, 8'd10, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, "accept"};
    vecs[9]  = '{0,  1'b0, 1'b0, 3'd0, 8'd0,  1'b0, 3'd0, 1'b0, 1'b1, 1'b0, "realign"};
    vecs[10] = '{14, 1'b0, 1'b0, 3'd0, 8'd0,  1'b0, 3'd0, 1'b0, 1'b1, 1'b0, "relock_early"};
    vecs[11] = '{0,  1'b0, 1'b0, 3'd0, 8'd0,  1'b0, 3'd0, 1'b1, 1'b1, 1'b0, "relock"};
    vecs[12] = '{30, 1'b0, 1'b1, 3'd1, 8'd10, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, "cfg_and_ps"};
    vecs[13] = '{5,  1'b1, 1'b0, 3'd0, 8'd0,  1'b0, 3'd0, 1'b0, 1'b0, 1'b0, "reset_wait"};
    vecs[14] = '{0,  1'b0, 1'b0, 3'd0, 8'd0,  1'b0, 3'd0, 1'b0, 1'b1, 1'b0, "restart"};
    vecs[15] = '{15, 1'b0, 1'b0, 3'd0, 8'd0,  1'b0, 3'd0, 1'b1, 1'b1, 1'b0, "relock_init"};

    for (int k = 0; k < NV; k++) begin
      for (int j = 0; j < vecs[k].idle; j++) idle();
      step(vecs[k].rst, vecs[k].cv, vecs[k].cc, vecs[k].cd, vecs[k].pp, vecs[k].ps);
      check({vecs[k].name, "_lock"},  32'(lock),      32'(vecs[k].e_lock));
      check({vecs[k].name, "_ready"}, 32'(cfg_ready), 32'(vecs[k].e_ready));
      check({vecs[k].name, "_err"},   32'(cfg_err),   32'(vecs[k].e_err));
    end

    // Power-up ratios are back after the mid-lock reset
    measure(1, hi, per);
    check("init_ch1_period", 32'(per), 32'd16);
    measure(2, hi, per);
    check("init_ch2_period", 32'(per), 32'd32);
    check("init_ch2_high", 32'(hi), 32'd16);

    // Phase step on channel 2 while locked
`ifdef CLK_DIV_MGR_PHASE_STEP_EN
    exp_lag = 1;
`else
    exp_lag = 0;
`endif
    step(1'b0, 1'b0, 3'd0, 8'd0, 1'b1, 3'd2);
    check("ps_lock", 32'(lock), 32'd1);
    idle();
    found = 0; n = 0; prev0 = clken[0];
    while (!found && n < 80) begin
      prev0 = clken[0];
      idle();
      n++;
      if (clken[2]) found = 1;
    end
    lag = !found ? 99 : (clken[0] ? 0 : (prev0 ? 1 : 2));
    check("ps_lag", 32'(lag), 32'(exp_lag));
    check("ps_lock_after", 32'(lock), 32'd1);

    // Reconfigure channel 1 to divide by 10
    step(1'b0, 1'b1, 3'd1, 8'd10, 1'b0, 3'd0);
    for (int j = 0; j < 17; j++) idle();
    check("div10_lock", 32'(lock), 32'd1);
    measure(1, hi, per);
    check("div10_period", 32'(per), 32'd10);
    check("div10_high", 32'(hi), 32'd5);

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      r  = ($urandom_range(0, 199) == 0);
      cv = ($urandom_range(0, 29) == 0);
      cc = 3'($urandom_range(0, 7));
      cd = 8'($urandom_range(0, 20));
      pp = ($urandom_range(0, 5) == 0);
      ps = 3'($urandom_range(0, 7));
      step(r, cv, cc, cd, pp, ps);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_mgr.md
CLK_DIV_MGR -- requirements
Module: clk_div_mgr

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, meaning number of divided-clock channels (1..8).
REQ-002 SHALL have parameter DIV_W, default 8, meaning width of each channel divide ratio.
REQ-003 SHALL have parameter DIV_INIT, default {8'd32,8'd16,8'd16}, meaning packed power-up divide ratios, channel 0 in the LSBs.
REQ-004 SHALL have parameter LOCK_CYCLES, default 16, meaning number of settle cycles before lock asserts (>=1).
REQ-005 SHALL have port clkin  input  1  meaning the single clock for all logic.
REQ-006 SHALL have port reset  input  1  meaning synchronous, active-high reset.
REQ-007 SHALL have port cfg_valid  input  1  meaning reconfiguration request.
REQ-008 SHALL have port cfg_ready  output  1  meaning reconfiguration can be accepted.
REQ-009 SHALL have port cfg_ch  input  3  meaning target channel index.
REQ-010 SHALL have port cfg_div  input  DIV_W  meaning new divide ratio.
REQ-011 SHALL have port cfg_err  output  1  meaning one-cycle pulse when a request is rejected.
REQ-012 SHALL have port ps_pulse  input  1  meaning phase-step request.
REQ-013 SHALL have port ps_sel  input  3  meaning phase-step channel.
REQ-014 SHALL have port clkout  output  NUM_CH  meaning divided clock per channel.
REQ-015 SHALL have port clken  output  NUM_CH  meaning one-cycle pulse per channel rising edge.
REQ-016 SHALL have port lock  output  1  meaning all channels aligned and settled.

Function
REQ-017 SHALL keep a per-channel counter cnt[i] that counts 0..div[i]-1 and wraps to 0.
REQ-018 SHALL drive clkout[i] and clken[i] as registers loaded with (cnt[i] < div[i]>>1) and (cnt[i]==0) respectively, one cycle after the counter value; div 3 gives 1 cycle high and 2 cycles low.
REQ-019 SHALL implement FSM states ALIGN, WAIT_LOCK and LOCKED.
REQ-020 SHALL, in ALIGN (one cycle), clear all cnt[i] and lock_cnt and then move to WAIT_LOCK.
REQ-021 SHALL, in WAIT_LOCK, increment lock_cnt each cycle and move to LOCKED when lock_cnt==LOCK_CYCLES-1.
REQ-022 SHALL register lock high in LOCKED, so that lock rises LOCK_CYCLES+1 cycles after ALIGN.
REQ-023 SHALL hold cfg_ready at 1 in WAIT_LOCK and LOCKED, and at 0 in ALIGN.
REQ-024 SHALL accept a request on cfg_valid&&cfg_ready, and SHALL treat a request with cfg_div>=2 and cfg_ch<NUM_CH as valid.
REQ-025 SHALL, for a valid request, load div[cfg_ch], clear lock the next cycle, enter ALIGN, and thereby realign all channels.
REQ-026 SHALL, for an invalid request, pulse cfg_err for 1 cycle and change no state; lock SHALL be unaffected.
REQ-027 SHALL, on ps_pulse in LOCKED with ps_sel<NUM_CH, hold cnt[ps_sel] for 1 cycle, delaying that channel by one clkin period, with lock staying 1.
REQ-028 SHALL ignore ps_pulse outside LOCKED and whenever ps_sel>=NUM_CH.
REQ-029 SHALL give an accepted cfg request priority over a ps_pulse in the same cycle, and SHALL drop the ps_pulse.

Reset
REQ-030 SHALL, while reset is high, force lock=0, cfg_ready=0, cfg_err=0, clkout=0, clken=0, cnt=0, lock_cnt=0, div=DIV_INIT and state=ALIGN.
REQ-031 SHALL, on reset mid-operation, discard all reconfiguration and phase steps and restart from DIV_INIT.

Configuration
REQ-032 SHALL, with CLK_DIV_MGR_PHASE_STEP_EN defined, implement REQ-027 to REQ-029.
REQ-033 SHALL, without CLK_DIV_MGR_PHASE_STEP_EN, keep ps_pulse and ps_sel as ports with no effect, and SHALL NOT build the phase-step logic.

Verification
REQ-034 SHALL cover: release reset with defaults -> clkout[0]/[1] period 16, clkout[2] period 32, all rising together, lock=1 exactly 17 cycles after reset deasserts.
REQ-035 SHALL cover: in LOCKED write cfg_ch=1, cfg_div=10 -> lock=0 next cycle, clkout[1] period 10 (5 high/5 low), all channels realigned, lock=1 after 17 more cycles.
REQ-036 SHALL cover: write cfg_div=1, then cfg_ch=5 -> cfg_err pulses 1 cycle each, lock stays 1, periods unchanged.
REQ-037 SHALL cover: with the macro defined, ps_pulse with ps_sel=2 in LOCKED -> clken[2] lags clken[0] by 1 cycle, lock stays 1; without the macro -> no lag.
REQ-038 SHALL cover: cfg accept and ps_pulse in the same cycle -> reconfiguration happens and no phase step occurs.
REQ-039 SHALL cover: assert reset during WAIT_LOCK after a reconfiguration -> all outputs 0, and DIV_INIT periods are restored after release.
